// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla remote responder: request/response payloads,
// AMO opcode encoding and the responder state enum.
package bsg_vanilla_pkg;

    localparam int unsigned data_width_gp   = 32;
    localparam int unsigned reg_id_width_gp = 5;
    localparam int unsigned mask_width_gp   = data_width_gp / 8;

    typedef enum logic [1:0] {
        e_vanilla_amoswap = 2'b00,
        e_vanilla_amoor   = 2'b01,
        e_vanilla_amoadd  = 2'b10,
        e_vanilla_amonop  = 2'b11
    } bsg_vanilla_amo_type_e;

    typedef struct packed {
        logic       float_wb;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } load_info_s;

    typedef struct packed {
        logic                       write_not_read;
        logic                       is_amo_op;
        bsg_vanilla_amo_type_e      amo_type;
        logic [mask_width_gp-1:0]   mask;
        load_info_s                 load_info;
        logic [reg_id_width_gp-1:0] reg_id;
        logic [data_width_gp-1:0]   data;
        logic [data_width_gp-1:0]   addr;
    } remote_req_s;

    typedef struct packed {
        logic [data_width_gp-1:0]   data;
        logic [reg_id_width_gp-1:0] reg_id;
        logic                       float_wb;
        logic                       is_unsigned_op;
        logic                       is_byte_op;
        logic                       is_hex_op;
        logic [1:0]                 part_sel;
    } remote_load_resp_s;

    typedef enum logic [1:0] {
        eIdle     = 2'b00,
        eLoadRead = 2'b01,
        eAmoWrite = 2'b10,
        eResp     = 2'b11
    } vanilla_remote_responder_state_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with byte write mask and one-cycle read latency.
// Ports: clk_i; v_i/w_i select access/write; addr_i word address; data_i and
// write_mask_i for writes; data_o holds the last read word until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int unsigned els_p         = 1024,
    parameter int unsigned data_width_p  = 32,
    parameter int unsigned addr_width_lp = $clog2(els_p),
    parameter int unsigned mask_width_lp = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]  data_o
);

    logic [data_width_p-1:0] mem_r [els_p];

    // Contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                for (int i = 0; i < int'(mask_width_lp); i++) begin
                    if (write_mask_i[i]) begin
                        mem_r[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
                    end
                end
            end else begin
                data_o <= mem_r[addr_i];
            end
        end
    end

endmodule

// File: rtl/vanilla_remote_responder.sv
// Remote memory responder: serves loads, byte-masked stores and AMOs against
// a local word memory, one request outstanding at a time.
// Ports: clk_i, reset_i (sync, active-high); remote_req_i/_v_i/_ready_o request
// handshake; remote_load_resp_o/_v_o/_yumi_i response handshake for loads and
// AMOs; credit_return_o pulses once per completed request.
module vanilla_remote_responder
    import bsg_vanilla_pkg::*;
#(
    parameter int unsigned els_p         = 1024,
    parameter int unsigned addr_width_lp = $clog2(els_p)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  remote_req_s       remote_req_i,
    input  logic              remote_req_v_i,
    output logic              remote_req_ready_o,
    output remote_load_resp_s remote_load_resp_o,
    output logic              remote_load_resp_v_o,
    input  logic              remote_load_resp_yumi_i,
    output logic              credit_return_o
);

    vanilla_remote_responder_state_e state_r, state_n;

    logic                       accept;
    logic                       is_store;
    logic                       is_amo;

    logic [addr_width_lp-1:0]   addr_r;
    logic [data_width_gp-1:0]   operand_r;
    bsg_vanilla_amo_type_e      amo_type_r;
    logic                       is_amo_r;
    logic [reg_id_width_gp-1:0] reg_id_r;
    load_info_s                 load_info_r;
    logic [data_width_gp-1:0]   data_r;
    logic                       store_credit_r;

    logic                       mem_v;
    logic                       mem_w;
    logic [addr_width_lp-1:0]   mem_addr;
    logic [data_width_gp-1:0]   mem_wdata;
    logic [mask_width_gp-1:0]   mem_mask;
    logic [data_width_gp-1:0]   mem_rdata;
    logic [data_width_gp-1:0]   amo_result;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{remote_req_i.addr[data_width_gp-1:addr_width_lp+2],
                                remote_req_i.addr[1:0]};

    assign is_amo             = remote_req_i.is_amo_op;
    assign is_store           = remote_req_i.write_not_read & ~remote_req_i.is_amo_op;
    assign remote_req_ready_o = (state_r == eIdle) & ~reset_i;
    assign accept             = remote_req_v_i & remote_req_ready_o;

    // AMO ALU: mem_rdata holds the old word during eAmoWrite.
    always_comb begin
        amo_result = mem_rdata;
        case (amo_type_r)
            e_vanilla_amoswap: amo_result = operand_r;
            e_vanilla_amoor:   amo_result = mem_rdata | operand_r;
            e_vanilla_amoadd:  amo_result = mem_rdata + operand_r;
            default:           amo_result = mem_rdata;
        endcase
    end

    // Next-state and memory port control.
    always_comb begin
        state_n   = state_r;
        mem_v     = 1'b0;
        mem_w     = 1'b0;
        mem_addr  = remote_req_i.addr[2 +: addr_width_lp];
        mem_wdata = remote_req_i.data;
        mem_mask  = remote_req_i.mask;
        case (state_r)
            eIdle: begin
                if (accept) begin
                    mem_v = 1'b1;
                    mem_w = is_store;
                    if (is_amo)         state_n = eAmoWrite;
                    else if (!is_store) state_n = eLoadRead;
                end
            end
            eLoadRead: state_n = eResp;
            eAmoWrite: begin
                // A reset in this cycle abandons the AMO, including its write.
                mem_v     = ~reset_i;
                mem_w     = 1'b1;
                mem_addr  = addr_r;
                mem_wdata = amo_result;
                mem_mask  = '1;
                state_n   = eResp;
            end
            eResp: begin
                if (remote_load_resp_yumi_i) state_n = eIdle;
            end
            default: state_n = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r        <= eIdle;
            addr_r         <= '0;
            operand_r      <= '0;
            amo_type_r     <= e_vanilla_amoswap;
            is_amo_r       <= 1'b0;
            reg_id_r       <= '0;
            load_info_r    <= '0;
            data_r         <= '0;
            store_credit_r <= 1'b0;
        end else begin
            state_r        <= state_n;
            store_credit_r <= accept & is_store;
            if (accept) begin
                addr_r      <= remote_req_i.addr[2 +: addr_width_lp];
                operand_r   <= remote_req_i.data;
                amo_type_r  <= remote_req_i.amo_type;
                is_amo_r    <= is_amo;
                reg_id_r    <= remote_req_i.reg_id;
                load_info_r <= remote_req_i.load_info;
            end
            if (state_r == eLoadRead || state_r == eAmoWrite) begin
                data_r <= mem_rdata;
            end
        end
    end

    assign remote_load_resp_v_o = (state_r == eResp) & ~reset_i;
    assign credit_return_o      = ~reset_i & (store_credit_r |
                                  ((state_r == eResp) & remote_load_resp_yumi_i));

    always_comb begin
        remote_load_resp_o.data           = data_r;
        remote_load_resp_o.reg_id         = reg_id_r;
        remote_load_resp_o.float_wb       = load_info_r.float_wb & ~is_amo_r;
        remote_load_resp_o.is_unsigned_op = load_info_r.is_unsigned_op;
        remote_load_resp_o.is_byte_op     = load_info_r.is_byte_op;
        remote_load_resp_o.is_hex_op      = load_info_r.is_hex_op;
        remote_load_resp_o.part_sel       = load_info_r.part_sel;
    end

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (els_p),
        .data_width_p (data_width_gp)
    ) mem (
        .clk_i        (clk_i),
        .v_i          (mem_v),
        .w_i          (mem_w),
        .addr_i       (mem_addr),
        .data_i       (mem_wdata),
        .write_mask_i (mem_mask),
        .data_o       (mem_rdata)
    );

endmodule

// File: tb/tb_vanilla_remote_responder.sv
// Self-checking bench: a transaction-level model predicts ready/resp/credit
// every cycle; directed scenarios also pin results to literal values.
module tb_vanilla_remote_responder;
    import bsg_vanilla_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    remote_req_s       req = '0;
    logic              req_v = 1'b0;
    logic              ready;
    remote_load_resp_s resp;
    logic              resp_v;
    logic              yumi = 1'b0;
    logic              credit;

    int nvec = 0;
    int nerr = 0;
    int credit_cnt = 0;

    always #5 clk = ~clk;

    vanilla_remote_responder #(.els_p(1024)) dut (
        .clk_i                   (clk),
        .reset_i                 (rst),
        .remote_req_i            (req),
        .remote_req_v_i          (req_v),
        .remote_req_ready_o      (ready),
        .remote_load_resp_o      (resp),
        .remote_load_resp_v_o    (resp_v),
        .remote_load_resp_yumi_i (yumi),
        .credit_return_o         (credit)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic remote_req_s mk(input logic wnr, input logic amo,
                                       input bsg_vanilla_amo_type_e t, input logic [3:0] m,
                                       input logic fw, input logic [4:0] rid,
                                       input logic [31:0] d, input logic [31:0] a);
        remote_req_s r;
        r = '0;
        r.write_not_read           = wnr;
        r.is_amo_op                = amo;
        r.amo_type                 = t;
        r.mask                     = m;
        r.load_info.float_wb       = fw;
        r.load_info.is_unsigned_op = rid[0];
        r.load_info.is_byte_op     = rid[1];
        r.load_info.is_hex_op      = rid[2];
        r.load_info.part_sel       = rid[4:3];
        r.reg_id                   = rid;
        r.data                     = d;
        r.addr                     = a;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0]       mdl_mem [1024];
    bit                busy, st_credit, acc;
    int                wait_n;
    bit                e_ready, e_rv, e_credit;
    remote_load_resp_s exp_resp;
    logic [31:0]       old_w, new_w;
    int                idx;

    initial begin
        busy = 0; st_credit = 0; wait_n = 0; exp_resp = '0;
        forever begin
            @(negedge clk);
            e_ready  = !rst && !busy;
            e_rv     = !rst && busy && wait_n == 0;
            e_credit = !rst && (st_credit || (e_rv && yumi));
            chk("ready", 64'(ready), 64'(e_ready));
            chk("resp_v", 64'(resp_v), 64'(e_rv));
            chk("credit", 64'(credit), 64'(e_credit));
            if (e_rv) chk("resp", 64'(resp), 64'(exp_resp));
            if (credit === 1'b1) credit_cnt++;
            acc = req_v && e_ready;
            @(posedge clk);
            if (rst) begin
                busy = 0; wait_n = 0; st_credit = 0;
            end else begin
                st_credit = acc && req.write_not_read && !req.is_amo_op;
                if (busy) begin
                    if (wait_n > 0) wait_n--;
                    else if (yumi) busy = 0;
                end else if (acc) begin
                    idx   = int'(req.addr[11:2]);
                    old_w = mdl_mem[idx];
                    if (req.is_amo_op || !req.write_not_read) begin
                        exp_resp.data           = old_w;
                        exp_resp.reg_id         = req.reg_id;
                        exp_resp.float_wb       = req.is_amo_op ? 1'b0 : req.load_info.float_wb;
                        exp_resp.is_unsigned_op = req.load_info.is_unsigned_op;
                        exp_resp.is_byte_op     = req.load_info.is_byte_op;
                        exp_resp.is_hex_op      = req.load_info.is_hex_op;
                        exp_resp.part_sel       = req.load_info.part_sel;
                        busy = 1; wait_n = 1;
                    end
                    if (req.is_amo_op) begin
                        case (req.amo_type)
                            e_vanilla_amoswap: new_w = req.data;
                            e_vanilla_amoor:   new_w = old_w | req.data;
                            e_vanilla_amoadd:  new_w = old_w + req.data;
                            default:           new_w = old_w;
                        endcase
                        mdl_mem[idx] = new_w;
                    end else if (req.write_not_read) begin
                        for (int b = 0; b < 4; b++)
                            if (req.mask[b]) mdl_mem[idx][b*8 +: 8] = req.data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input remote_req_s r);
        bit got = 0;
        req = r; req_v = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (ready === 1'b1);
        end
        if (!got) begin
            nvec++; nerr++;
            $display("FAIL issue_timeout: ready got 0 expected 1");
        end
        @(posedge clk); #1;
        req_v = 1'b0;
    endtask

    task automatic take_resp(input int hold, output logic [31:0] d, output logic [4:0] rid,
                             output logic fw);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (resp_v === 1'b1);
        end
        if (!seen) begin
            nvec++; nerr++;
            $display("FAIL resp_timeout: resp_v got 0 expected 1");
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        yumi = 1'b1;
        @(negedge clk);
        d = resp.data; rid = resp.reg_id; fw = resp.float_wb;
        @(posedge clk); #1;
        yumi = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [31:0] a, input logic [4:0] rid_in,
                            input int hold, input logic [31:0] exp_d);
        logic [31:0] d; logic [4:0] rid; logic fw;
        issue(mk(1'b0, 1'b0, e_vanilla_amoswap, 4'h0, 1'b1, rid_in, 32'h0, a));
        take_resp(hold, d, rid, fw);
        chk(name, 64'(d), 64'(exp_d));
        chk({name, "_reg_id"}, 64'(rid), 64'(rid_in));
        chk({name, "_float_wb"}, 64'(fw), 64'(1'b1));
    endtask

    task automatic amo_chk(input string name, input bsg_vanilla_amo_type_e t, input logic [31:0] a,
                           input logic [31:0] dat, input logic [31:0] exp_d);
        logic [31:0] d; logic [4:0] rid; logic fw;
        issue(mk(1'b0, 1'b1, t, 4'h0, 1'b1, 5'd9, dat, a));
        take_resp(0, d, rid, fw);
        chk(name, 64'(d), 64'(exp_d));
        chk({name, "_float_wb"}, 64'(fw), 64'(1'b0));
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        issue(mk(1'b1, 1'b0, e_vanilla_amoswap, m, 1'b0, 5'd0, d, a));
    endtask

    initial begin
        int c0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // store then load with credit count
        c0 = credit_cnt;
        store(32'h10, 32'hDEADBEEF, 4'b1111);
        load_chk("ld_deadbeef", 32'h10, 5'd5, 0, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("credits_s1", 64'(credit_cnt - c0), 64'd2);

        // byte-masked merge
        store(32'h20, 32'h11223344, 4'b1111);
        store(32'h20, 32'hAA000000, 4'b1000);
        load_chk("ld_merge", 32'h20, 5'd7, 0, 32'hAA223344);

        // AMO sequence
        store(32'h30, 32'h00000005, 4'b1111);
        amo_chk("amoadd", e_vanilla_amoadd, 32'h30, 32'hFFFFFFFF, 32'h00000005);
        load_chk("ld_after_add", 32'h30, 5'd3, 0, 32'h00000004);
        amo_chk("amoor", e_vanilla_amoor, 32'h30, 32'h000000F0, 32'h00000004);
        amo_chk("amoswap", e_vanilla_amoswap, 32'h30, 32'h00000001, 32'h000000F4);
        amo_chk("amonop", e_vanilla_amonop, 32'h30, 32'h00000077, 32'h00000001);
        load_chk("ld_after_nop", 32'h30, 5'd30, 0, 32'h00000001);

        // yumi withheld for 10 cycles
        load_chk("ld_hold", 32'h10, 5'd17, 10, 32'hDEADBEEF);

        // back-to-back stores, then read them back
        store(32'h50, 32'h01010101, 4'b1111);
        store(32'h54, 32'h02020202, 4'b1111);
        store(32'h58, 32'h03030303, 4'b1111);
        store(32'h5C, 32'h04040404, 4'b1111);
        load_chk("ld_b2b_0", 32'h50, 5'd1, 0, 32'h01010101);
        load_chk("ld_b2b_3", 32'h5C, 5'd2, 0, 32'h04040404);

        // upper and byte-offset address bits ignored
        store(32'h8000_1013, 32'h0BADF00D, 4'b1111);
        load_chk("ld_alias", 32'h10, 5'd11, 0, 32'h0BADF00D);

        // yumi outside eResp is ignored; it then completes the response at once
        yumi = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(mk(1'b0, 1'b0, e_vanilla_amoswap, 4'h0, 1'b0, 5'd4, 32'h0, 32'h50));
        repeat (3) @(posedge clk);
        #1 yumi = 1'b0;

        // reset while the AMO is in its write cycle
        issue(mk(1'b0, 1'b1, e_vanilla_amoadd, 4'h0, 1'b0, 5'd6, 32'h1, 32'h40));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        load_chk("ld_after_reset", 32'h54, 5'd8, 0, 32'h02020202);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vanilla_remote_responder.md
VANILLA_REMOTE_RESPONDER -- requirements
Module: vanilla_remote_responder

Interface
REQ-001 SHALL have parameter els_p, default 1024, meaning number of 32-bit words in the local backing memory (power of 2).
REQ-002 SHALL have parameter addr_width_lp, derived as `$clog2(els_p)`, meaning the word-address width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port remote_req_i, input, remote_req_s: the incoming request.
REQ-006 SHALL have port remote_req_v_i, input, 1 bit: the request is valid.
REQ-007 SHALL have port remote_req_ready_o, output, 1 bit: the responder accepts the request this cycle.
REQ-008 SHALL have port remote_load_resp_o, output, remote_load_resp_s: the load/AMO response.
REQ-009 SHALL have port remote_load_resp_v_o, output, 1 bit: the response is valid.
REQ-010 SHALL have port remote_load_resp_yumi_i, input, 1 bit: the consumer takes the response.
REQ-011 SHALL have port credit_return_o, output, 1 bit: one-cycle pulse per completed request.

Function
REQ-012 SHALL accept a request on a cycle where remote_req_v_i & remote_req_ready_o; remote_req_ready_o = 1 only in state eIdle.
REQ-013 SHALL index memory with word address addr[2+:addr_width_lp]; upper address bits are ignored.
REQ-014 SHALL implement FSM states eIdle, eLoadRead, eAmoWrite, eResp.
REQ-015 SHALL, for a load accepted in cycle N: issue the memory read in N, go to eLoadRead, capture the read word at the end of N+1, go to eResp, and assert remote_load_resp_v_o from N+2.
REQ-016 SHALL, for a store accepted in cycle N: perform a byte-masked write (mask[i] enables byte i) in N, pulse credit_return_o in N+1, produce no load response, and stay in eIdle, so it is ready again in N+1.
REQ-017 SHALL, for an AMO accepted in N: read in N; in N+1 (eAmoWrite), write the new full word and capture the old word; go to eResp; remote_load_resp_v_o from N+2; mask is ignored.
REQ-018 SHALL compute the AMO new value as: amoswap = data; amoor = old | data; amoadd = (old + data) mod 2^32; amo_type 2'b11 rewrites the old value unchanged.
REQ-019 SHALL, in eResp, set data = captured word (full 32-bit, unshifted) and copy reg_id from the request; float_wb, is_unsigned_op, is_byte_op, is_hex_op and part_sel come from load_info; for AMO, float_wb = 0.
REQ-020 SHALL hold remote_load_resp_o stable while remote_load_resp_v_o = 1 and yumi is absent.
REQ-021 SHALL, on yumi in eResp, go to eIdle and pulse credit_return_o in the same cycle.
REQ-022 SHALL treat yumi asserted outside eResp as ignored.
REQ-023 SHALL process requests strictly in order, one outstanding at a time.
REQ-024 SHALL give a write issued in cycle N read-after-write visibility to any read issued in N+1 or later.

Reset
REQ-025 SHALL, while reset_i = 1, force state eIdle, remote_req_ready_o = 0, remote_load_resp_v_o = 0, credit_return_o = 0, and captured registers to 0.
REQ-026 SHALL, on reset mid-operation, abandon the in-flight request: no response and no credit; memory contents already written are retained.
REQ-027 SHALL NOT initialize memory contents by reset.

Structure
REQ-028 SHALL take remote_req_s, remote_load_resp_s and bsg_vanilla_amo_type_e from bsg_vanilla_pkg.
REQ-029 SHALL add the state enum vanilla_remote_responder_state_e to bsg_vanilla_pkg.
REQ-030 SHALL use a single sub-module: bsg_mem_1rw_sync_mask_write_byte (els_p x 32, byte mask, one cycle read latency).
REQ-031 SHALL keep the AMO ALU inline as combinational logic.

Verification
REQ-032 Scenario: store addr 0x10, data 0xDEADBEEF, mask 4'b1111; then load addr 0x10, reg_id 5 -> response data 0xDEADBEEF, reg_id 5, resp_v two cycles after load accept; two credit pulses total.
REQ-033 Scenario: store 0x11223344 full mask; then store 0xAA000000 mask 4'b1000; then load -> data 0xAA223344.
REQ-034 Scenario: word = 0x00000005, amoadd data 0xFFFFFFFF -> response 0x00000005; subsequent load -> 0x00000004; amoor 0xF0 -> response 0x4, memory becomes 0xF4; amoswap 0x1 -> response 0xF4.
REQ-035 Scenario: load, then yumi withheld 10 cycles -> resp_v stays 1, response unchanged, ready 0, no credit until the yumi cycle.
REQ-036 Scenario: back-to-back stores every cycle -> ready stays 1, one credit pulse per store, each lagging its store by one cycle.
REQ-037 Scenario: reset_i asserted in eAmoWrite -> next cycle resp_v 0, credit 0, state eIdle, ready 1 after reset deasserts.
